// File: rtl/bnn_ctrl_pkg.sv
// Shared types and constants for the BNN OCR session controller.
// State encodings are visible on current_state, so the values are fixed.
package bnn_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CMD        = 3'd1,
        ST_IMG_RX     = 3'd2,
        ST_INFERENCE  = 3'd3,
        ST_RESULT_RDY = 3'd4,
        ST_TX         = 3'd5,
        ST_CLEAR      = 3'd6,
        ST_ERROR      = 3'd7
    } state_t;

    localparam logic [7:0] CMD_LOAD  = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_CLEAR = 8'h03;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_BAD_CMD = 3'd1,
        ERR_ABORT   = 3'd2,
        ERR_TIMEOUT = 3'd3,
        ERR_SPI     = 3'd4
    } err_t;

    // Status byte returned first in a READ transaction.
    function automatic logic [7:0] status_byte(input logic valid, input err_t err);
        return {valid, 4'b0000, err};
    endfunction

endpackage

// File: rtl/bnn_watchdog.sv
// Saturating cycle counter guarding the inference phase.
// expired stays high once the count reaches TIMEOUT_CYCLES until cleared.
module bnn_watchdog #(
    parameter int TIMEOUT_CYCLES = 65536,
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LIMIT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (count_reg == LIMIT);

endmodule

// File: rtl/bnn_session_ctrl.sv
// SPI session controller: decodes per-transaction commands, streams image bytes
// into the buffer, launches and watches inference, and reports status over SPI.
module bnn_session_ctrl
    import bnn_ctrl_pkg::*;
#(
    parameter int IMG_BYTES      = 128,
    parameter int RES_W          = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int AW             = $clog2(IMG_BYTES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             CS,
    input  logic             byte_valid,
    input  logic [7:0]       rx_byte,
    input  logic             spi_error,
    input  logic             tx_done,
    output logic             byte_ready,
    output logic [7:0]       tx_byte,
    output logic             buffer_write_enable,
    output logic [AW-1:0]    buffer_addr,
    output logic             clear_buffer,
    input  logic             clear_done,
    output logic             infer_start,
    input  logic             result_ready,
    input  logic [RES_W-1:0] result_class,
    output logic             busy,
    output logic [2:0]       error_code,
    output logic [2:0]       current_state
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_BYTES - 1);

    state_t             state_reg;
    state_t             state_next;
    err_t               err_event;
    err_t               error_code_reg;
    logic [7:0]         tx_byte_reg;
    logic [AW-1:0]      byte_cnt_reg;
    logic [RES_W-1:0]   result_reg;
    logic               result_valid_reg;
    logic [1:0]         tx_idx_reg;
    logic               infer_first_reg;
    logic               wd_expired;
    logic               enter_inference;
    logic               write_fire;
    logic               last_byte;
    logic               clear_fire;
    logic               tx_start;
    logic [7:0]         result_byte;

    assign write_fire      = (state_reg == ST_IMG_RX) && byte_valid;
    assign last_byte       = (byte_cnt_reg == LAST_ADDR);
    assign clear_fire      = (state_reg == ST_CLEAR) && clear_done;
    assign tx_start        = (state_reg == ST_CMD) && (state_next == ST_TX);
    assign enter_inference = (state_reg != ST_INFERENCE) && (state_next == ST_INFERENCE);

    // Zero-extend the latched class into the second READ byte.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_result_byte
            if (gi < RES_W) begin : g_bit
                assign result_byte[gi] = result_reg[gi];
            end else begin : g_zero
                assign result_byte[gi] = 1'b0;
            end
        end
    endgenerate

    bnn_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (enter_inference),
        .enable (state_reg == ST_INFERENCE),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Priority everywhere is spi_error > CS high > byte/tx events, except that
    // the final image byte still completes the load when CS rises with it.
    always_comb begin
        state_next = state_reg;
        err_event  = ERR_NONE;
        case (state_reg)
            ST_IDLE: begin
                if (!CS) state_next = ST_CMD;
            end
            ST_CMD: begin
                if (spi_error) begin
                    state_next = ST_ERROR;
                    err_event  = ERR_SPI;
                end else if (CS) begin
                    state_next = ST_IDLE;
                end else if (byte_valid) begin
                    case (rx_byte)
                        CMD_LOAD:  state_next = ST_IMG_RX;
                        CMD_READ:  state_next = ST_TX;
                        CMD_CLEAR: state_next = ST_CLEAR;
                        default: begin
                            state_next = ST_ERROR;
                            err_event  = ERR_BAD_CMD;
                        end
                    endcase
                end
            end
            ST_IMG_RX: begin
                if (spi_error) begin
                    state_next = ST_ERROR;
                    err_event  = ERR_SPI;
                end else if (byte_valid && last_byte) begin
                    state_next = ST_INFERENCE;
                end else if (CS) begin
                    state_next = ST_ERROR;
                    err_event  = ERR_ABORT;
                end
            end
            ST_INFERENCE: begin
                if (result_ready) begin
                    state_next = ST_RESULT_RDY;
                end else if (wd_expired) begin
                    state_next = ST_ERROR;
                    err_event  = ERR_TIMEOUT;
                end
            end
            ST_RESULT_RDY: begin
                if (CS) state_next = ST_IDLE;
            end
            ST_TX: begin
                if (spi_error) begin
                    state_next = ST_ERROR;
                    err_event  = ERR_SPI;
                end else if (CS) begin
                    state_next = ST_IDLE;
                end else if (tx_done && (tx_idx_reg == 2'd1)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clear_done) state_next = ST_IDLE;
            end
            ST_ERROR: begin
                if (CS) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        byte_ready          = (state_reg == ST_TX) && (tx_idx_reg < 2'd2);
        buffer_write_enable = write_fire;
        clear_buffer        = (state_reg == ST_CLEAR);
        infer_start         = infer_first_reg;
        busy                = (state_reg == ST_INFERENCE) || (state_reg == ST_CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_code_reg   <= ERR_NONE;
            tx_byte_reg      <= '0;
            byte_cnt_reg     <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            tx_idx_reg       <= '0;
            infer_first_reg  <= 1'b0;
        end else begin
            infer_first_reg <= enter_inference;

            if ((state_reg == ST_CMD) && (state_next == ST_IMG_RX)) begin
                byte_cnt_reg <= '0;
            end else if (write_fire) begin
                byte_cnt_reg <= last_byte ? '0 : byte_cnt_reg + 1'b1;
            end else if (clear_fire) begin
                byte_cnt_reg <= '0;
            end

            if (tx_start) begin
                tx_idx_reg  <= '0;
                tx_byte_reg <= status_byte(result_valid_reg, error_code_reg);
            end else if ((state_reg == ST_TX) && tx_done && (tx_idx_reg < 2'd2)) begin
                tx_idx_reg <= tx_idx_reg + 1'b1;
                if (tx_idx_reg == 2'd0) tx_byte_reg <= result_byte;
            end

            if ((state_reg == ST_INFERENCE) && result_ready) begin
                result_reg       <= result_class;
                result_valid_reg <= 1'b1;
            end else if (clear_fire) begin
                result_reg       <= '0;
                result_valid_reg <= 1'b0;
            end

            // First error sticks until a CLEAR completes.
            if (clear_fire) begin
                error_code_reg <= ERR_NONE;
            end else if ((err_event != ERR_NONE) && (error_code_reg == ERR_NONE)) begin
                error_code_reg <= err_event;
            end
        end
    end

    assign tx_byte       = tx_byte_reg;
    assign buffer_addr   = byte_cnt_reg;
    assign error_code    = error_code_reg;
    assign current_state = state_reg;

endmodule

// File: tb/tb_bnn_session_ctrl.sv
// Directed bench for bnn_session_ctrl with an 8-byte image and 16-cycle timeout.
module tb_bnn_session_ctrl;

    localparam int IMG_BYTES = 8;
    localparam int RES_W     = 4;
    localparam int TIMEOUT   = 16;
    localparam int AW        = $clog2(IMG_BYTES);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cs;
    logic             byte_valid;
    logic [7:0]       rx_byte;
    logic             spi_error;
    logic             tx_done;
    logic             byte_ready;
    logic [7:0]       tx_byte;
    logic             buffer_write_enable;
    logic [AW-1:0]    buffer_addr;
    logic             clear_buffer;
    logic             clear_done;
    logic             infer_start;
    logic             result_ready;
    logic [RES_W-1:0] result_class;
    logic             busy;
    logic [2:0]       error_code;
    logic [2:0]       current_state;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int wr_cnt;
    int start_cnt;

    always #5 clk = ~clk;

    bnn_session_ctrl #(
        .IMG_BYTES     (IMG_BYTES),
        .RES_W         (RES_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .CS                 (cs),
        .byte_valid         (byte_valid),
        .rx_byte            (rx_byte),
        .spi_error          (spi_error),
        .tx_done            (tx_done),
        .byte_ready         (byte_ready),
        .tx_byte            (tx_byte),
        .buffer_write_enable(buffer_write_enable),
        .buffer_addr        (buffer_addr),
        .clear_buffer       (clear_buffer),
        .clear_done         (clear_done),
        .infer_start        (infer_start),
        .result_ready       (result_ready),
        .result_class       (result_class),
        .busy               (busy),
        .error_code         (error_code),
        .current_state      (current_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("check %-22s got 0x%0h ok", tag, got);
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        rx_byte    = b;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic do_clear();
        cs = 1'b0;
        tick();
        send_byte(8'h03);
        cs         = 1'b1;
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
        check("clear_back_idle", current_state, 3'd0);
    endtask

    // CS low, LOAD, and the given number of image bytes (addresses checked).
    task automatic load_bytes(input int n);
        cs = 1'b0;
        tick();
        send_byte(8'h01);
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'b1;
            rx_byte    = 8'(8'h10 + i);
            #1;
            if (buffer_write_enable && (int'(buffer_addr) == i)) wr_cnt++;
            @(posedge clk);
            #1;
            byte_valid = 1'b0;
            if (infer_start) start_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0; cs = 1'b1; byte_valid = 1'b0; rx_byte = '0; spi_error = 1'b0;
        tx_done = 1'b0; clear_done = 1'b0; result_ready = 1'b0; result_class = '0;
        #12;
        check("reset_state", current_state, 3'd0);
        check("reset_outputs", {byte_ready, tx_byte, buffer_write_enable, buffer_addr,
                                clear_buffer, infer_start, busy, error_code}, '0);
        #5 rst_n = 1'b1;
        tick();

        // Load then infer
        wr_cnt = 0; start_cnt = 0;
        load_bytes(IMG_BYTES);
        check("load_writes", wr_cnt, IMG_BYTES);
        check("load_in_inference", current_state, 3'd3);
        check("load_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (infer_start) start_cnt++;
        end
        check("infer_start_once", start_cnt, 1);
        result_class = 4'd5; result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("result_rdy_state", current_state, 3'd4);
        cs = 1'b1;
        tick();
        check("result_to_idle", current_state, 3'd0);

        // Read
        cs = 1'b0;
        tick();
        send_byte(8'h02);
        check("read_state", current_state, 3'd5);
        check("read_status_byte", {byte_ready, tx_byte}, {1'b1, 8'h80});
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("read_result_byte", {byte_ready, tx_byte}, {1'b1, 8'h05});
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("read_done_idle", current_state, 3'd0);
        cs = 1'b1;
        tick();

        // Abort, after clearing the earlier result
        do_clear();
        load_bytes(3);
        cs = 1'b1;
        tick();
        check("abort_error_state", current_state, 3'd7);
        check("abort_code", error_code, 3'd2);
        tick();
        check("abort_then_idle", current_state, 3'd0);
        cs = 1'b0;
        tick();
        send_byte(8'h02);
        check("abort_status", tx_byte, 8'h02);
        cs = 1'b1;
        tick();
        check("read_cs_high_idle", current_state, 3'd0);
        do_clear();

        // Timeout
        load_bytes(IMG_BYTES);
        for (int i = 0; i < 10; i++) tick();
        check("timeout_not_early", current_state, 3'd3);
        for (int i = 0; i < 20 && current_state != 3'd7; i++) tick();
        check("timeout_error_state", current_state, 3'd7);
        check("timeout_code", error_code, 3'd3);
        cs = 1'b1;
        tick();
        cs = 1'b0;
        tick();
        spi_error = 1'b1;
        tick();
        spi_error = 1'b0;
        check("sticky_after_spi", error_code, 3'd3);
        cs = 1'b1;
        tick();
        do_clear();
        check("clear_code", error_code, 3'd0);
        cs = 1'b0;
        tick();
        send_byte(8'h02);
        check("clear_status_byte", tx_byte, 8'h00);
        cs = 1'b1;
        tick();

        // Bad command, then spi_error coincident with a command byte
        cs = 1'b0;
        tick();
        send_byte(8'hFF);
        check("bad_cmd_code", error_code, 3'd1);
        cs = 1'b1;
        tick();
        do_clear();
        cs = 1'b0;
        tick();
        spi_error = 1'b1;
        send_byte(8'h01);
        spi_error = 1'b0;
        check("spi_beats_byte", error_code, 3'd4);
        check("spi_error_state", current_state, 3'd7);
        cs = 1'b1;
        tick();
        do_clear();

        // Final byte together with CS high still completes the load
        load_bytes(IMG_BYTES - 1);
        byte_valid = 1'b1; rx_byte = 8'hAA; cs = 1'b1;
        tick();
        byte_valid = 1'b0;
        check("final_byte_cs_high", current_state, 3'd3);
        check("final_byte_no_error", error_code, 3'd0);
        result_class = 4'd9; result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        tick();
        check("final_back_idle", current_state, 3'd0);

        // Asynchronous reset in the middle of a load
        load_bytes(2);
        check("mid_load_state", current_state, 3'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_state", current_state, 3'd0);
        check("async_reset_outputs", {byte_ready, tx_byte, buffer_write_enable, buffer_addr,
                                      clear_buffer, infer_start, busy, error_code}, '0);
        #4 rst_n = 1'b1;
        cs = 1'b1;
        tick();
        check("post_reset_idle", current_state, 3'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
